// File: rtl/dut.sv
// -----------------------------------------------------------------------------
// dut: self-checking built-in-test block.
//
// After reset a 16-bit Galois LFSR produces NUM_BYTES pseudo-random bytes.
// Each byte is folded into a CRC-8 twice: once by a byte-wide parallel engine
// (one edge per byte, in LOAD) and once by a bit-serial engine (eight edges per
// byte, in SHIFT). After the last byte the two CRCs are compared and the
// result is latched on passed/failed until the next reset.
//
// Ports:
//   clk     in   rising-edge clock for all state
//   reset   in   asynchronous, active-high; clears all state
//   passed  out  registered; high once both CRCs matched, held until reset
//   failed  out  registered; high once the CRCs mismatched, held until reset
// -----------------------------------------------------------------------------
module dut #(
  parameter int unsigned NUM_BYTES    = 8,        // 1..10
  parameter logic [15:0] SEED         = 16'hACE1, // non-zero
  parameter logic [7:0]  CRC_POLY     = 8'h07,    // x^8 term implicit
  parameter bit          INJECT_FAULT = 1'b0      // flips serial CRC bit 0 at compare
) (
  input  logic clk,
  input  logic reset,
  output logic passed,
  output logic failed
);

  localparam logic [3:0]  LAST_IDX  = 4'(NUM_BYTES - 1);
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    LOAD,
    SHIFT,
    COMPARE,
    DONE
  } state_t;

  state_t      state_q,  state_d;
  logic [15:0] lfsr_q,   lfsr_d;
  logic [7:0]  crc_p_q,  crc_p_d;
  logic [7:0]  crc_s_q,  crc_s_d;
  logic [7:0]  shreg_q,  shreg_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [3:0]  idx_q,    idx_d;
  logic        passed_q, passed_d;
  logic        failed_q, failed_d;

  logic        fb;
  logic        match;

  // Byte-wide CRC update: eight MSB-first serial steps unrolled into one
  // combinational stage. Data is shifted so only its top bit is ever read.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc,
                                           input logic [7:0] data);
    logic [7:0] c;
    logic [7:0] d;
    c = crc;
    d = data;
    for (int unsigned i = 0; i < 8; i++) begin
      c = {c[6:0], 1'b0} ^ ((c[7] ^ d[7]) ? CRC_POLY : 8'h00);
      d = {d[6:0], 1'b0};
    end
    return c;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= LOAD;
      lfsr_q   <= SEED;
      crc_p_q  <= '0;
      crc_s_q  <= '0;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      idx_q    <= '0;
      passed_q <= 1'b0;
      failed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      crc_p_q  <= crc_p_d;
      crc_s_q  <= crc_s_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      idx_q    <= idx_d;
      passed_q <= passed_d;
      failed_q <= failed_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    crc_p_d  = crc_p_q;
    crc_s_d  = crc_s_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    idx_d    = idx_q;
    passed_d = passed_q;
    failed_d = failed_q;

    fb    = crc_s_q[7] ^ shreg_q[7];
    match = (crc_p_q == (crc_s_q ^ {7'b0, INJECT_FAULT}));

    unique case (state_q)
      LOAD: begin
        crc_p_d  = crc8_byte(crc_p_q, lfsr_q[7:0]);
        shreg_d  = lfsr_q[7:0];
        bitcnt_d = '0;
        lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
        state_d  = SHIFT;
      end

      SHIFT: begin
        crc_s_d  = {crc_s_q[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
        shreg_d  = {shreg_q[6:0], 1'b0};
        bitcnt_d = bitcnt_q + 3'd1;
        if (bitcnt_q == 3'd7) begin
          if (idx_q == LAST_IDX) begin
            state_d = COMPARE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = LOAD;
          end
        end
      end

      COMPARE: begin
        passed_d = match;
        failed_d = !match;
        state_d  = DONE;
      end

      DONE: begin
        state_d = DONE;
      end

      default: begin
        state_d = LOAD;
      end
    endcase
  end

  assign passed = passed_q;
  assign failed = failed_q;

endmodule

// File: tb/tb_dut.sv
// -----------------------------------------------------------------------------
// tb_dut: bench for the CRC built-in-test block.
//
// Three instances share clock and reset: default parameters (u0), forced
// fault (u1) and a single-byte run (u2). A per-edge expectation table for the
// default run is built from an LFSR/CRC model at the start, then replayed
// against u0/u1/u2. Hand-written sequences cover reset values, hold in DONE
// and an asynchronous reset in the middle of a run.
// -----------------------------------------------------------------------------
module tb_dut;

  localparam int unsigned NB    = 8;
  localparam int unsigned NEDGE = 9 * NB + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic p0, f0, p1, f1, p2, f2;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    logic [15:0] lfsr;
    logic [7:0]  crc_p;
    logic [7:0]  crc_s;
    logic        passed;
    logic        failed;
  } vec_t;

  vec_t        tbl [NEDGE];
  logic [15:0] lm  [NB + 1];
  logic [7:0]  pm  [NB + 1];

  always #5 clk = ~clk;

  dut #(.NUM_BYTES(8), .SEED(16'hACE1), .CRC_POLY(8'h07), .INJECT_FAULT(1'b0))
    u0 (.clk(clk), .reset(rst), .passed(p0), .failed(f0));
  dut #(.NUM_BYTES(8), .SEED(16'hACE1), .CRC_POLY(8'h07), .INJECT_FAULT(1'b1))
    u1 (.clk(clk), .reset(rst), .passed(p1), .failed(f1));
  dut #(.NUM_BYTES(1), .SEED(16'hACE1), .CRC_POLY(8'h07), .INJECT_FAULT(1'b0))
    u2 (.clk(clk), .reset(rst), .passed(p2), .failed(f2));

  function automatic logic [15:0] lfsr_model(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Serial CRC state after n bits of byte b, derived from the classic
  // "xor byte in, then shift" register: the serial register equals that
  // register with the not-yet-consumed data bits removed.
  function automatic logic [7:0] crc_part(input logic [7:0] c,
                                          input logic [7:0] b,
                                          input int unsigned n);
    logic [7:0] r;
    logic [7:0] rest;
    r = c ^ b;
    for (int unsigned i = 0; i < n; i++)
      r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    rest = b << n;
    return r ^ rest;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_p0"},    32'(p0), 32'(0));
    chk({tag, "_f0"},    32'(f0), 32'(0));
    chk({tag, "_lfsr"},  32'(u0.lfsr_q), 32'(16'hACE1));
    chk({tag, "_crcp"},  32'(u0.crc_p_q), 32'(0));
    chk({tag, "_crcs"},  32'(u0.crc_s_q), 32'(0));
    chk({tag, "_p1f1"},  32'({p1, f1}), 32'(0));
    chk({tag, "_p2f2"},  32'({p2, f2}), 32'(0));
  endtask

  // Replays the first n table rows; edge 1 is the first posedge after release.
  task automatic run_table(input int unsigned n);
    vec_t v;
    for (int unsigned e = 1; e <= n; e++) begin
      step();
      v = tbl[e - 1];
      chk($sformatf("u0_lfsr_e%0d", e),  32'(u0.lfsr_q),  32'(v.lfsr));
      chk($sformatf("u0_crcp_e%0d", e),  32'(u0.crc_p_q), 32'(v.crc_p));
      chk($sformatf("u0_crcs_e%0d", e),  32'(u0.crc_s_q), 32'(v.crc_s));
      chk($sformatf("u0_pf_e%0d", e),    32'({p0, f0}),   32'({v.passed, v.failed}));
      chk($sformatf("u1_pf_e%0d", e),    32'({p1, f1}),   32'({1'b0, v.passed}));
      chk($sformatf("u2_pf_e%0d", e),    32'({p2, f2}),   32'({e >= 10, 1'b0}));
      if (e == 1) begin
        chk("u0_lfsr_after_first_load", 32'(u0.lfsr_q),  32'(16'hE270));
        chk("u0_crcp_first_byte",       32'(u0.crc_p_q), 32'(8'hA9));
        chk("u2_shreg_byte",            32'(u2.shreg_q), 32'(8'hE1));
        chk("u2_crcp_e1",               32'(u2.crc_p_q), 32'(8'hA9));
      end
      if (e == 9)
        chk("u2_crcs_e9", 32'(u2.crc_s_q), 32'(8'hA9));
    end
  endtask

  task automatic do_reset(input int unsigned cycles);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    check_reset_values("rst_hold");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Build the expectation table for the default configuration.
    lm[0] = 16'hACE1;
    pm[0] = 8'h00;
    for (int unsigned k = 0; k < NB; k++) begin
      lm[k + 1] = lfsr_model(lm[k]);
      pm[k + 1] = crc_part(pm[k], lm[k][7:0], 8);
    end
    for (int unsigned e = 1; e <= NEDGE; e++) begin
      int unsigned k;
      int unsigned ph;
      k  = (e - 1) / 9;
      ph = (e - 1) % 9;
      if (k >= NB) begin
        tbl[e - 1] = '{lfsr: lm[NB], crc_p: pm[NB], crc_s: pm[NB], passed: 1'b1, failed: 1'b0};
      end else begin
        tbl[e - 1] = '{lfsr: lm[k + 1], crc_p: pm[k + 1],
                       crc_s: crc_part(pm[k], lm[k][7:0], ph),
                       passed: 1'b0, failed: 1'b0};
      end
    end

    // Run 1: full default run, fault run and single-byte run in parallel.
    do_reset(5);
    run_table(NEDGE);

    // Terminal state holds for 20 more edges.
    for (int unsigned i = 0; i < 20; i++) begin
      step();
      chk("done_pf0",  32'({p0, f0}),    32'({1'b1, 1'b0}));
      chk("done_pf1",  32'({p1, f1}),    32'({1'b0, 1'b1}));
      chk("done_lfsr", 32'(u0.lfsr_q),   32'(lm[NB]));
      chk("done_crcp", 32'(u0.crc_p_q),  32'(pm[NB]));
      chk("done_crcs", 32'(u0.crc_s_q),  32'(pm[NB]));
    end

    // Reset from DONE, run 40 edges, then reset asynchronously mid-run.
    do_reset(2);
    run_table(40);
    rst = 1'b1;
    #1;
    check_reset_values("async_rst");
    do_reset(2);
    run_table(NEDGE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
